pc_sequencer: RTL and testbench

//  Owns the fetch PC for the 5-stage MIPS pipeline and drives the instruction-ROM index.

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/pc_sequencer_npc.sv | 45 ++++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the fetch-PC sequencer: reset PC, exception entry
//   PC, instruction-ROM index width and the sequencer state encoding.
//   No ports.
package pc_sequencer_pkg;

    localparam logic [31:0] PC_START   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam int          ROM_AW     = 10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } seq_state_t;

    // Sign-extend a 16-bit word offset and scale it to a byte offset.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_npc.sv
// pc_sequencer_npc (npc_calc)
//   Combinational redirect-target calculation and redirect select.
//   The D-stage link-address logic can reuse it.
//   Ports:
//     i_pc          current fetch PC (the delay-slot PC, i.e. branch PC + 4)
//     i_br_taken    branch resolved taken
//     i_br_pc       PC of the branch instruction
//     i_br_imm      branch word offset
//     i_j_en        j/jal in D
//     i_j_index     jump instr_index
//     i_jr_en       jr/jalr in D
//     i_jr_target   forwarded rs value
//     o_t_br        branch target
//     o_t_j         jump target
//     o_redirect    any redirect requested
//     o_target      selected target (br > j > jr)
module pc_sequencer_npc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_pc,
    input  logic [15:0] i_br_imm,
    input  logic        i_j_en,
    input  logic [25:0] i_j_index,
    input  logic        i_jr_en,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_t_br,
    output logic [31:0] o_t_j,
    output logic        o_redirect,
    output logic [31:0] o_target
);

    assign o_t_br     = i_br_pc + 32'd4 + br_offset(i_br_imm);
    // Region bits come from the delay-slot PC, which is the current fetch PC.
    assign o_t_j      = {i_pc[31:28], i_j_index, 2'b00};
    assign o_redirect = i_br_taken | i_j_en | i_jr_en;

    always_comb begin
        o_target = i_jr_target;
        if (i_br_taken)  o_target = o_t_br;
        else if (i_j_en) o_target = o_t_j;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the fetch PC and drives the instruction-ROM index. Selects the next
//   PC from sequential, branch, jump, register-jump, exception vector and
//   eret sources. A redirect that arrives while D is stalled is parked and
//   applied when the stall releases. Keeps EPC.
//   Ports:
//     i_clk, i_reset          clock; synchronous active-high reset
//     i_stall                 freeze PC this cycle
//     i_br_*, i_j_*, i_jr_*   D-stage redirect requests and operands
//     i_exc_req, i_exc_pc     M-stage exception and faulting PC
//     i_eret                  M-stage eret
//     o_pc                    current fetch PC
//     o_im_addr               ROM word index (pc[ROM_AW+1:2])
//     o_epc                   saved exception PC
//     o_pend                  redirect parked, waiting for stall release
//     o_misaligned            pc[1:0] != 0, flag only
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] P_PC_START   = PC_START,
    parameter logic [31:0] P_EXC_VECTOR = EXC_VECTOR,
    parameter int          P_ROM_AW     = ROM_AW
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic                i_br_taken,
    input  logic [31:0]         i_br_pc,
    input  logic [15:0]         i_br_imm,
    input  logic                i_j_en,
    input  logic [25:0]         i_j_index,
    input  logic                i_jr_en,
    input  logic [31:0]         i_jr_target,
    input  logic                i_exc_req,
    input  logic [31:0]         i_exc_pc,
    input  logic                i_eret,
    output logic [31:0]         o_pc,
    output logic [P_ROM_AW-1:0] o_im_addr,
    output logic [31:0]         o_epc,
    output logic                o_pend,
    output logic                o_misaligned
);

    seq_state_t  r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_epc, w_epc_nxt;
    logic [31:0] r_pend_target, w_pend_target_nxt;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_t_br;
    logic [31:0] w_t_j;

    pc_sequencer_npc u_npc (
        .i_pc        (r_pc),
        .i_br_taken  (i_br_taken),
        .i_br_pc     (i_br_pc),
        .i_br_imm    (i_br_imm),
        .i_j_en      (i_j_en),
        .i_j_index   (i_j_index),
        .i_jr_en     (i_jr_en),
        .i_jr_target (i_jr_target),
        .o_t_br      (w_t_br),
        .o_t_j       (w_t_j),
        .o_redirect  (w_redirect),
        .o_target    (w_target)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_RUN;
            r_pc          <= P_PC_START;
            r_epc         <= 32'd0;
            r_pend_target <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_epc         <= w_epc_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end

    // Exception and eret override stall and any parked redirect; otherwise
    // RUN either advances/redirects or parks, and PEND waits out the stall.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_epc_nxt         = r_epc;
        w_pend_target_nxt = r_pend_target;
        if (i_exc_req) begin
            w_pc_nxt    = P_EXC_VECTOR;
            w_epc_nxt   = i_exc_pc;
            w_state_nxt = ST_RUN;
        end else if (i_eret) begin
            w_pc_nxt    = r_epc;
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_stall) begin
                        if (w_redirect) begin
                            w_pend_target_nxt = w_target;
                            w_state_nxt       = ST_PEND;
                        end
                    end else if (w_redirect) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end
                ST_PEND: begin
                    // First capture wins; redirect inputs are ignored here.
                    if (!i_stall) begin
                        w_pc_nxt    = r_pend_target;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign o_pc         = r_pc;
    assign o_im_addr    = r_pc[P_ROM_AW+1:2];
    assign o_epc        = r_epc;
    assign o_pend       = (r_state == ST_PEND);
    assign o_misaligned = |r_pc[1:0];

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, j_en, jr_en, exc_req, eret;
    logic [31:0] br_pc, jr_target, exc_pc;
    logic [15:0] br_imm;
    logic [25:0] j_index;
    logic [31:0] pc, epc;
    logic [9:0]  im_addr;
    logic        pend, misaligned;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_stall      (stall),
        .i_br_taken   (br_taken),
        .i_br_pc      (br_pc),
        .i_br_imm     (br_imm),
        .i_j_en       (j_en),
        .i_j_index    (j_index),
        .i_jr_en      (jr_en),
        .i_jr_target  (jr_target),
        .i_exc_req    (exc_req),
        .i_exc_pc     (exc_pc),
        .i_eret       (eret),
        .o_pc         (pc),
        .o_im_addr    (im_addr),
        .o_epc        (epc),
        .o_pend       (pend),
        .o_misaligned (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; stall = 0; br_taken = 0; j_en = 0; jr_en = 0;
        exc_req = 0; eret = 0; br_pc = 0; jr_target = 0; exc_pc = 0;
        br_imm = 0; j_index = 0;

        // 1: reset then sequential fetch
        step(); step();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_epc", epc, 32'h0);
        chk("rst_pend", {31'd0, pend}, 32'd0);
        chk("rst_im", {22'd0, im_addr}, 32'h0);
        reset = 0;
        step(); chk("seq1", pc, 32'h3004);
        step(); chk("seq2", pc, 32'h3008);
        step(); chk("seq3", pc, 32'h300C);
        chk("seq3_im", {22'd0, im_addr}, 32'h003);

        // 2: taken branches, negative and positive offsets
        br_taken = 1; br_pc = 32'h3008; br_imm = 16'hFFFE;
        step(); chk("br_neg", pc, 32'h3004);
        br_imm = 16'h0003;
        step(); chk("br_pos", pc, 32'h3018);
        br_taken = 0;

        // 3: jump captured under stall, later redirects ignored
        jr_en = 1; jr_target = 32'h3010;
        step(); chk("jr_setup", pc, 32'h3010);
        jr_en = 0;
        stall = 1; j_en = 1; j_index = 26'h0000C40;
        step();
        chk("stall_hold", pc, 32'h3010);
        chk("stall_pend", {31'd0, pend}, 32'd1);
        j_en = 0; jr_en = 1; jr_target = 32'h5000;
        step(); step();
        chk("pend_hold", pc, 32'h3010);
        chk("pend_still", {31'd0, pend}, 32'd1);
        stall = 0;
        step();
        chk("release_pc", pc, 32'h3100);
        chk("release_pend", {31'd0, pend}, 32'd0);
        jr_en = 0;

        // 4: exception overrides stall and pending redirect, then eret
        stall = 1; br_taken = 1; br_pc = 32'h3100; br_imm = 16'h0000;
        step(); chk("pend_br", {31'd0, pend}, 32'd1);
        br_taken = 0; exc_req = 1; exc_pc = 32'h3024;
        step();
        chk("exc_pc", pc, 32'h4180);
        chk("exc_epc", epc, 32'h3024);
        chk("exc_pend", {31'd0, pend}, 32'd0);
        exc_req = 0; stall = 0;
        step(); chk("handler", pc, 32'h4184);
        eret = 1;
        step(); chk("eret_pc", pc, 32'h3024);
        eret = 0;

        // 5: exc_req beats eret; reset from PEND
        exc_req = 1; eret = 1; exc_pc = 32'h3050;
        step();
        chk("exc_eret_pc", pc, 32'h4180);
        chk("exc_eret_epc", epc, 32'h3050);
        exc_req = 0; eret = 0;
        stall = 1; j_en = 1;
        step(); chk("pend_j", {31'd0, pend}, 32'd1);
        reset = 1;
        step();
        chk("rst2_pc", pc, 32'h3000);
        chk("rst2_pend", {31'd0, pend}, 32'd0);
        chk("rst2_epc", epc, 32'h0);
        reset = 0; stall = 0; j_en = 0;

        // 6: wrap and misalignment
        jr_en = 1; jr_target = 32'hFFFF_FFFC;
        step(); chk("top", pc, 32'hFFFF_FFFC);
        jr_en = 0;
        step(); chk("wrap", pc, 32'h0);
        chk("wrap_mis", {31'd0, misaligned}, 32'd0);
        jr_en = 1; jr_target = 32'h3002;
        step();
        chk("mis_pc", pc, 32'h3002);
        chk("mis_flag", {31'd0, misaligned}, 32'd1);

        // Redirect priority: branch over jump over jr
        br_taken = 1; j_en = 1; jr_en = 1;
        br_pc = 32'h3100; br_imm = 16'h0001; j_index = 26'h0000C40; jr_target = 32'h5000;
        step(); chk("prio_br", pc, 32'h3108);
        br_taken = 0;
        step(); chk("prio_j", pc, 32'h3100);
        j_en = 0; jr_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
